// File: rtl/keypad_event_ctrl_if.sv
// Keypad event controller bus: CPU-side controls and status plus the filtered key pulse vector.
// The master drives requests; the slave (controller) drives event status.
interface keypad_event_ctrl_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [15:0]   key_pulse;
    logic          irq_en;
    logic          pop;
    logic          flush;
    logic          ovf_clr;
    logic          evt_valid;
    logic [3:0]    evt_code;
    logic [CW-1:0] count;
    logic          ovf;
    logic          irq;

    modport master (
        output key_pulse, irq_en, pop, flush, ovf_clr,
        input  evt_valid, evt_code, count, ovf, irq
    );

    modport slave (
        input  key_pulse, irq_en, pop, flush, ovf_clr,
        output evt_valid, evt_code, count, ovf, irq
    );
endinterface

// File: rtl/keypad_event_ctrl.sv
// Keypad event queue: latches key pulses into a pending set, serialises them round-robin
// into 4-bit codes held in a FWFT FIFO, and raises a level interrupt while work is outstanding.
module keypad_event_ctrl #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_event_ctrl_if.slave   bus
);
    localparam int unsigned NKEY = 16;
    localparam int unsigned KW   = 4;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;

    logic [NKEY-1:0] pend_q, pend_d;
    logic [KW-1:0]   last_q, last_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [KW-1:0]   mem_q [DEPTH];

    logic            grant_found;
    logic [KW-1:0]   grant_idx;
    logic [KW-1:0]   scan_idx;
    logic [NKEY-1:0] grant_vec;
    logic            can_push;
    logic            push;
    logic            pop_eff;

    // Round-robin search starting just above the last granted key
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 1; i <= int'(NKEY); i++) begin
            scan_idx = last_q + KW'(i);
            if (!grant_found && pend_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign can_push  = (count_q != CW'(DEPTH)) || bus.pop;
    assign push      = grant_found && can_push && !bus.flush;
    assign pop_eff   = bus.pop && (count_q != '0) && !bus.flush;
    assign grant_vec = push ? (NKEY'(1) << grant_idx) : '0;

    always_comb begin
        pend_d   = (pend_q & ~grant_vec) | bus.key_pulse;
        last_d   = push ? grant_idx : last_q;
        wr_ptr_d = push ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_eff ? PW'(rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        unique case ({push, pop_eff})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase

        // A set condition overrides a simultaneous clear
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if ((bus.key_pulse & pend_q & ~grant_vec) != '0) begin
            ovf_d = 1'b1;
        end

        if (bus.flush) begin
            pend_d   = '0;
            last_d   = KW'(NKEY - 1);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            last_q   <= KW'(NKEY - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign bus.evt_valid = (count_q != '0);
    assign bus.evt_code  = bus.evt_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;
    assign bus.irq       = bus.irq_en & (bus.evt_valid | ovf_q);
endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed self-checking bench for keypad_event_ctrl with DEPTH=8.
module tb_keypad_event_ctrl;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    keypad_event_ctrl_if #(.DEPTH(DEPTH)) bus ();

    keypad_event_ctrl #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] keys);
        bus.key_pulse = keys;
        tick();
        bus.key_pulse = '0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input int code);
        check_eq(tag, 32'(bus.evt_code), 32'(code));
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.key_pulse = '0;
        bus.irq_en    = 1'b1;
        bus.pop       = 1'b0;
        bus.flush     = 1'b0;
        bus.ovf_clr   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_eq("rst_valid", 32'(bus.evt_valid), 32'd0);
        check_eq("rst_code",  32'(bus.evt_code),  32'd0);
        check_eq("rst_count", 32'(bus.count),     32'd0);
        check_eq("rst_ovf",   32'(bus.ovf),       32'd0);
        check_eq("rst_irq",   32'(bus.irq),       32'd0);

        // Single key: two-cycle latency, pop clears
        pulse(16'h0020);
        check_eq("lat_n1_valid", 32'(bus.evt_valid), 32'd0);
        tick();
        check_eq("single_valid", 32'(bus.evt_valid), 32'd1);
        check_eq("single_code",  32'(bus.evt_code),  32'd5);
        check_eq("single_count", 32'(bus.count),     32'd1);
        check_eq("single_irq",   32'(bus.irq),       32'd1);
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        check_eq("single_pop_valid", 32'(bus.evt_valid), 32'd0);
        check_eq("single_pop_irq",   32'(bus.irq),       32'd0);
        check_eq("single_pop_count", 32'(bus.count),     32'd0);

        // Simultaneous keys, then round-robin continuation after 12
        do_flush();
        pulse(16'h1208);
        repeat (3) tick();
        check_eq("rr_count3", 32'(bus.count),    32'd3);
        check_eq("rr_head",   32'(bus.evt_code), 32'd3);
        pulse(16'h4008);
        repeat (2) tick();
        check_eq("rr_count5", 32'(bus.count), 32'd5);
        pop_expect("rr_code0", 3);
        pop_expect("rr_code1", 9);
        pop_expect("rr_code2", 12);
        pop_expect("rr_code3", 14);
        pop_expect("rr_code4", 3);
        check_eq("rr_empty", 32'(bus.count), 32'd0);
        check_eq("rr_ovf",   32'(bus.ovf),   32'd0);

        // Twelve keys into an 8-deep FIFO: saturate then drain without loss
        do_flush();
        pulse(16'h0FFF);
        repeat (10) tick();
        check_eq("sat_count", 32'(bus.count), 32'd8);
        check_eq("sat_ovf",   32'(bus.ovf),   32'd0);
        pop_expect("sat_code0", 0);
        check_eq("full_pushpop_count", 32'(bus.count), 32'd8);
        check_eq("full_pushpop_head",  32'(bus.evt_code), 32'd1);
        for (int k = 1; k < 12; k++) pop_expect($sformatf("sat_code%0d", k), k);
        check_eq("sat_drained", 32'(bus.count), 32'd0);
        check_eq("sat_ovf_end", 32'(bus.ovf),   32'd0);

        // Overflow: key 7 pending behind a full FIFO, then re-pulsed
        do_flush();
        pulse(16'hFF00);
        repeat (10) tick();
        check_eq("ovf_full", 32'(bus.count), 32'd8);
        pulse(16'h0080);
        tick();
        check_eq("ovf_pend_hold", 32'(bus.count), 32'd8);
        check_eq("ovf_pre",       32'(bus.ovf),   32'd0);
        pulse(16'h0080);
        check_eq("ovf_set", 32'(bus.ovf), 32'd1);
        check_eq("ovf_irq", 32'(bus.irq), 32'd1);
        bus.ovf_clr = 1'b1;
        pulse(16'h0080);
        bus.ovf_clr = 1'b0;
        check_eq("ovf_set_wins", 32'(bus.ovf), 32'd1);
        for (int k = 8; k < 16; k++) pop_expect($sformatf("ovf_code%0d", k), k);
        pop_expect("ovf_code7", 7);
        check_eq("ovf_drained_valid", 32'(bus.evt_valid), 32'd0);
        check_eq("ovf_drained_ovf",   32'(bus.ovf),       32'd1);
        check_eq("ovf_drained_irq",   32'(bus.irq),       32'd1);
        bus.irq_en = 1'b0;
        #1;
        check_eq("irq_masked", 32'(bus.irq), 32'd0);
        bus.irq_en  = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check_eq("ovf_cleared", 32'(bus.ovf), 32'd0);
        check_eq("ovf_clr_irq", 32'(bus.irq), 32'd0);

        // Pop while empty
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        check_eq("empty_pop_count", 32'(bus.count),     32'd0);
        check_eq("empty_pop_valid", 32'(bus.evt_valid), 32'd0);

        // Flush with five queued, ovf set, and pulses on the flush cycle
        pulse(16'h003E);
        pulse(16'h0020);
        repeat (5) tick();
        check_eq("fl_count5", 32'(bus.count),    32'd5);
        check_eq("fl_head",   32'(bus.evt_code), 32'd1);
        check_eq("fl_ovf1",   32'(bus.ovf),      32'd1);
        bus.key_pulse = 16'h00F0;
        do_flush();
        bus.key_pulse = '0;
        check_eq("fl_count", 32'(bus.count),     32'd0);
        check_eq("fl_valid", 32'(bus.evt_valid), 32'd0);
        check_eq("fl_ovf",   32'(bus.ovf),       32'd0);
        check_eq("fl_code",  32'(bus.evt_code),  32'd0);
        repeat (4) tick();
        check_eq("fl_no_stale", 32'(bus.count), 32'd0);

        // Asynchronous reset in the middle of a burst
        pulse(16'h00FF);
        repeat (3) tick();
        check_eq("burst_count", 32'(bus.count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(bus.evt_valid), 32'd0);
        check_eq("arst_count", 32'(bus.count),     32'd0);
        check_eq("arst_code",  32'(bus.evt_code),  32'd0);
        check_eq("arst_ovf",   32'(bus.ovf),       32'd0);
        check_eq("arst_irq",   32'(bus.irq),       32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_eq("arst_after", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
